// File: rtl/audio_pkg.sv
// Shared audio datapath types and constants used by the volume scaler and its
// multiplier.
package audio_pkg;

  localparam int WAVE_W = 8;
  localparam int VOL_W  = 8;
  localparam int PROD_W = WAVE_W + VOL_W + 1;

  typedef logic signed [WAVE_W-1:0] sample_t;
  typedef logic        [VOL_W-1:0]  vol_t;

  // Offset that turns a signed sample into an offset-binary PWM duty value.
  localparam logic [WAVE_W-1:0] PWM_OFFSET = {1'b1, {(WAVE_W-1){1'b0}}};

  // Adding half-scale modulo 2**WAVE_W only flips the MSB.
  function automatic logic [WAVE_W-1:0] to_pwm(input sample_t s);
    return s ^ PWM_OFFSET;
  endfunction

endpackage

// File: rtl/volume_scaler_su_mult.sv
// Combinational signed-by-unsigned multiplier; kept separate so a DSP
// primitive or shift-add version can be dropped in.
module su_mult
  import audio_pkg::*;
(
  input  sample_t                  a,
  input  vol_t                     b,
  output logic signed [PROD_W-1:0] p
);

  // Zero-extending b keeps it non-negative in the signed product.
  assign p = PROD_W'(a) * $signed({1'b0, b});

endmodule

// File: rtl/volume_scaler.sv
// Scales a signed wave sample by an unsigned volume captured on the sample
// strobe; two-stage pipeline with signed and offset-binary outputs.
module volume_scaler
  import audio_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  sample_t           wave,
  input  vol_t              volume,
  output sample_t           amplitude,
  output logic [WAVE_W-1:0] amp_pwm,
  output logic              valid
);

  sample_t                  wave_q;
  vol_t                     cur_vol;
  logic                     v1;
  logic signed [PROD_W-1:0] prod;
  sample_t                  scaled;

  su_mult u_mult (
    .a (wave_q),
    .b (cur_vol),
    .p (prod)
  );

  // Arithmetic shift floors toward -inf; the result always fits WAVE_W bits.
  assign scaled = sample_t'(prod >>> VOL_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      wave_q    <= '0;
      cur_vol   <= '0;
      v1        <= 1'b0;
      amplitude <= '0;
      amp_pwm   <= PWM_OFFSET;
      valid     <= 1'b0;
    end else begin
      if (en) begin
        wave_q  <= wave;
        cur_vol <= volume;
      end
      v1    <= en;
      valid <= v1;
      if (v1) begin
        amplitude <= scaled;
        amp_pwm   <= to_pwm(scaled);
      end
    end
  end

endmodule

// File: tb/tb_volume_scaler.sv
// Directed bench for volume_scaler with a timed scoreboard of expected samples.
module tb_volume_scaler;
  import audio_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  sample_t           wave;
  vol_t              volume;
  sample_t           amplitude;
  logic [WAVE_W-1:0] amp_pwm;
  logic              valid;

  always #5 clk = ~clk;

  volume_scaler dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .wave      (wave),
    .volume    (volume),
    .amplitude (amplitude),
    .amp_pwm   (amp_pwm),
    .valid     (valid)
  );

  typedef struct {
    int due;
    int amp;
  } exp_t;

  exp_t sb[$];
  int   cycle    = 0;
  int   total    = 0;
  int   bad      = 0;
  int   last_amp = 0;

  function automatic int model(input int w, input int v);
    int p;
    int q;
    p = w * v;
    q = p / 256;
    if (p < 0 && q * 256 != p) q = q - 1;
    return q;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cycle, obs, exp_v);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    if (sb.size() > 0 && sb[0].due == cycle) begin
      e = sb.pop_front();
      check("valid", {31'b0, valid}, 1);
      check("amplitude", 32'($signed(amplitude)), e.amp);
      check("amp_pwm", {24'b0, amp_pwm}, (e.amp + 128) & 255);
      last_amp = e.amp;
      $display("txn cycle=%0d amplitude=%0d amp_pwm=0x%02h expected=%0d",
               cycle, $signed(amplitude), amp_pwm, e.amp);
    end else begin
      check("valid_idle", {31'b0, valid}, 0);
      check("hold_amplitude", 32'($signed(amplitude)), last_amp);
      check("hold_amp_pwm", {24'b0, amp_pwm}, (last_amp + 128) & 255);
    end
  endtask

  task automatic drive(input logic e, input int w, input int v);
    en     = e;
    wave   = w[7:0];
    volume = v[7:0];
    if (e && !reset) sb.push_back('{cycle + 2, model(w, v)});
  endtask

  // Reset discards everything in flight; en is low when reset releases.
  task automatic do_reset(input int n);
    reset = 1'b1;
    sb.delete();
    last_amp = 0;
    repeat (n) tick();
    reset = 1'b0;
    drive(1'b0, 0, 0);
  endtask

  int pairs[6] = '{-1, 1, 1, 255, -128, 0};

  initial begin
    // Reset held with a live strobe must produce nothing.
    reset  = 1'b1;
    en     = 1'b1;
    wave   = 8'sd5;
    volume = 8'd255;
    do_reset(3);
    repeat (2) tick();

    drive(1'b1, 127, 255);
    tick();
    drive(1'b0, 0, 0);
    repeat (3) tick();

    drive(1'b1, -128, 128);
    tick();
    drive(1'b0, -128, 128);
    repeat (3) tick();

    for (int i = 0; i < 6; i += 2) begin
      drive(1'b1, pairs[i], pairs[i+1]);
      tick();
      drive(1'b0, 0, 0);
      repeat (3) tick();
    end

    // Volume and wave changes without a strobe must not disturb outputs.
    drive(1'b1, 50, 100);
    tick();
    drive(1'b0, 50, 100);
    repeat (10) tick();
    drive(1'b0, 50, 255);
    repeat (3) tick();
    drive(1'b0, -90, 255);
    repeat (3) tick();
    drive(1'b1, 50, 255);
    tick();
    drive(1'b0, 0, 0);
    repeat (3) tick();

    // Back-to-back strobes over the full ramp.
    for (int w = -128; w <= 127; w++) begin
      drive(1'b1, w, 200);
      tick();
    end
    drive(1'b0, 0, 0);
    repeat (3) tick();

    // Reset while the pipeline is busy.
    for (int w = 0; w < 10; w++) begin
      drive(1'b1, w * 7 - 30, 200);
      tick();
    end
    en = 1'b0;
    do_reset(1);
    repeat (3) tick();

    drive(1'b1, -100, 77);
    tick();
    drive(1'b0, 0, 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
